// File: rtl/cmos_window_capture.sv
// Windowed, optionally decimated CMOS pixel capture with start/stop frame arming.
// Produces a linear frame-buffer address plus an N-bank interleaved address/select.
//
// state   | meaning
// IDLE    | not capturing, waiting for iSTART (iEND low)
// ARMED   | waiting for the next rising edge of frame valid
// CAPTURE | inside a captured frame, window pixels are forwarded
module cmos_window_capture #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16,
    parameter int ADDR_W    = 19,
    parameter int WIN_W     = 640,
    parameter int WIN_H     = 480,
    parameter int NUM_BANKS = 4,
    parameter int DECIM     = 1
) (
    input  logic                                  iCLK,
    input  logic                                  iRST_N,
    input  logic [DATA_W-1:0]                     iDATA,
    input  logic                                  iFVAL,
    input  logic                                  iLVAL,
    input  logic                                  iSTART,
    input  logic                                  iEND,
    input  logic [CNT_W-1:0]                      iX_POS,
    input  logic [CNT_W-1:0]                      iY_POS,
    output logic [DATA_W-1:0]                     oDATA,
    output logic                                  oDVAL,
    output logic [CNT_W-1:0]                      oX_Cont,
    output logic [CNT_W-1:0]                      oY_Cont,
    output logic                                  oSYNC,
    output logic                                  oFRAME_DONE,
    output logic [31:0]                           oFrame_Cont,
    output logic [ADDR_W-1:0]                     oADDR,
    output logic [NUM_BANKS-1:0]                  oBANK_SEL,
    output logic [ADDR_W-$clog2(NUM_BANKS)-1:0]   oBANK_ADDR
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam int               DEC_SH   = $clog2(DECIM);
    localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'(DECIM - 1);
    localparam logic [CNT_W:0]   X_SPAN   = (CNT_W+1)'(WIN_W * DECIM);
    localparam logic [CNT_W:0]   Y_SPAN   = (CNT_W+1)'(WIN_H * DECIM);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIN_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIN_W);

    logic [DATA_W-1:0] r_data;
    logic              r_fval, r_lval, fval_d, lval_d;
    logic [CNT_W-1:0]  x_cnt, y_cnt, x_pos_q, y_pos_q;
    logic [1:0]        state;
    logic              end_req;
    logic [ADDR_W-1:0] row_base;

    logic              fval_rise, fval_fall, lval_fall;
    logic              start_frame, capturing, keep;
    logic [CNT_W-1:0]  x_org, y_org, x_off, y_off, col, row;
    logic              x_in, y_in;

    always_comb begin
        fval_rise   = r_fval & ~fval_d;
        fval_fall   = ~r_fval & fval_d;
        lval_fall   = ~r_lval & lval_d;
        start_frame = (state == S_ARMED) && fval_rise && !iEND;
        capturing   = (state == S_CAPTURE) || start_frame;
        // the window origin takes effect on the very first cycle of the frame
        x_org       = start_frame ? iX_POS : x_pos_q;
        y_org       = start_frame ? iY_POS : y_pos_q;
        x_off       = x_cnt - x_org;
        y_off       = y_cnt - y_org;
        x_in        = (x_cnt >= x_org) && ({1'b0, x_off} < X_SPAN) && ((x_off & DEC_MASK) == '0);
        y_in        = (y_cnt >= y_org) && ({1'b0, y_off} < Y_SPAN) && ((y_off & DEC_MASK) == '0);
        col         = x_off >> DEC_SH;
        row         = y_off >> DEC_SH;
        keep        = capturing && r_lval && x_in && y_in;
    end

    // Frame valid keeps tracking the pad during reset so that a release mid-frame
    // is not mistaken for a frame start.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_data <= '0;
            r_fval <= iFVAL;
            r_lval <= 1'b0;
            fval_d <= 1'b1;
            lval_d <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            r_data <= iDATA;
            r_fval <= iFVAL;
            r_lval <= iLVAL;
            fval_d <= r_fval;
            lval_d <= r_lval;
            if (!r_lval)
                x_cnt <= '0;
            else if (x_cnt != '1)
                x_cnt <= x_cnt + CNT_W'(1);
            if (!r_fval)
                y_cnt <= '0;
            else if (lval_fall && (y_cnt != '1))
                y_cnt <= y_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state       <= S_IDLE;
            end_req     <= 1'b0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
            oSYNC       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFrame_Cont <= '0;
        end else begin
            oSYNC       <= start_frame;
            oFRAME_DONE <= 1'b0;
            if (start_frame) begin
                x_pos_q <= iX_POS;
                y_pos_q <= iY_POS;
            end
            case (state)
                S_IDLE: begin
                    end_req <= 1'b0;
                    if (iSTART && !iEND)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    end_req <= 1'b0;
                    if (iEND)
                        state <= S_IDLE;
                    else if (fval_rise)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (fval_fall) begin
                        oFRAME_DONE <= 1'b1;
                        oFrame_Cont <= oFrame_Cont + 32'd1;
                        state       <= (end_req || iEND) ? S_IDLE : S_ARMED;
                        end_req     <= 1'b0;
                    end else if (iEND) begin
                        end_req <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // row_base tracks row*WIN_W for the next window line without a multiplier
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            row_base <= '0;
            oDATA    <= '0;
            oDVAL    <= 1'b0;
            oX_Cont  <= '0;
            oY_Cont  <= '0;
            oADDR    <= '0;
        end else begin
            if (!r_fval)
                row_base <= '0;
            else if (capturing && lval_fall && y_in && (row < LAST_ROW))
                row_base <= row_base + ROW_STEP;

            oDVAL <= keep;
            if (keep) begin
                oDATA   <= r_data;
                oX_Cont <= col;
                oY_Cont <= row;
                oADDR   <= (col == '0) ? row_base : oADDR + ADDR_W'(1);
            end else if (start_frame) begin
                oADDR <= '0;
            end
        end
    end

    generate
        if (NUM_BANKS == 1) begin : g_one_bank
            assign oBANK_SEL  = oDVAL;
            assign oBANK_ADDR = oADDR;
        end else begin : g_banks
            always_comb begin
                oBANK_SEL = '0;
                oBANK_SEL[oADDR[$clog2(NUM_BANKS)-1:0]] = oDVAL;
            end
            assign oBANK_ADDR = oADDR[ADDR_W-1:$clog2(NUM_BANKS)];
        end
    endgenerate

endmodule

// File: tb/tb_cmos_window_capture.sv
// Scoreboard bench for cmos_window_capture: two instances (8x4 / 4 banks / no decimation,
// and 4x2 / 1 bank / decimation 2) share one randomized sensor stream.
module tb_cmos_window_capture;

    localparam int A_W = 8, A_H = 4, A_D = 1;
    localparam int B_W = 4, B_H = 2, B_D = 2;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst_n, fval, lval, start, stop;
    logic [7:0]  data;
    logic [15:0] xpos, ypos;

    logic [7:0]  a_data, b_data;
    logic        a_dval, b_dval, a_sync, b_sync, a_done, b_done;
    logic [15:0] a_x, a_y, b_x, b_y;
    logic [31:0] a_fc, b_fc;
    logic [4:0]  a_addr;
    logic [3:0]  a_sel;
    logic [2:0]  a_baddr;
    logic [2:0]  b_addr;
    logic [0:0]  b_sel;
    logic [2:0]  b_baddr;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp = 0, n_err = 0;
    int   frames_exp = 0;
    int   a_sync_n = 0, a_done_n = 0, b_sync_n = 0, b_done_n = 0;

    cmos_window_capture #(.DATA_W(8), .CNT_W(16), .ADDR_W(5), .WIN_W(A_W), .WIN_H(A_H),
                          .NUM_BANKS(4), .DECIM(A_D)) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
        .iSTART(start), .iEND(stop), .iX_POS(xpos), .iY_POS(ypos),
        .oDATA(a_data), .oDVAL(a_dval), .oX_Cont(a_x), .oY_Cont(a_y), .oSYNC(a_sync),
        .oFRAME_DONE(a_done), .oFrame_Cont(a_fc), .oADDR(a_addr), .oBANK_SEL(a_sel),
        .oBANK_ADDR(a_baddr));

    cmos_window_capture #(.DATA_W(8), .CNT_W(16), .ADDR_W(3), .WIN_W(B_W), .WIN_H(B_H),
                          .NUM_BANKS(1), .DECIM(B_D)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
        .iSTART(start), .iEND(stop), .iX_POS(xpos), .iY_POS(ypos),
        .oDATA(b_data), .oDVAL(b_dval), .oX_Cont(b_x), .oY_Cont(b_y), .oSYNC(b_sync),
        .oFRAME_DONE(b_done), .oFrame_Cont(b_fc), .oADDR(b_addr), .oBANK_SEL(b_sel),
        .oBANK_ADDR(b_baddr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window membership straight from the window/decimation rules.
    function automatic void model_pixel(input int x, input int y, input int xp, input int yp,
                                        input logic [7:0] d);
        exp_t e;
        int dx, dy;
        dx = x - xp;
        dy = y - yp;
        if (dx >= 0 && dy >= 0 && dx < A_W*A_D && dy < A_H*A_D && dx % A_D == 0 && dy % A_D == 0) begin
            e.d    = d;
            e.x    = 16'(dx / A_D);
            e.y    = 16'(dy / A_D);
            e.addr = 32'((dy / A_D) * A_W + dx / A_D);
            qa.push_back(e);
        end
        if (dx >= 0 && dy >= 0 && dx < B_W*B_D && dy < B_H*B_D && dx % B_D == 0 && dy % B_D == 0) begin
            e.d    = d;
            e.x    = 16'(dx / B_D);
            e.y    = 16'(dy / B_D);
            e.addr = 32'((dy / B_D) * B_W + dx / B_D);
            qb.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (a_sync) a_sync_n++;
        if (a_done) a_done_n++;
        if (a_dval) begin
            if (qa.size() == 0) begin
                check("a_unexpected_dval", 32'(a_dval), 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_data", 32'(a_data), 32'(ea.d));
                check("a_x_cont", 32'(a_x), 32'(ea.x));
                check("a_y_cont", 32'(a_y), 32'(ea.y));
                check("a_addr", 32'(a_addr), ea.addr);
                check("a_bank_sel", 32'(a_sel), 32'd1 << ea.addr[1:0]);
                check("a_bank_addr", 32'(a_baddr), ea.addr >> 2);
            end
        end else begin
            check("a_bank_sel_idle", 32'(a_sel), 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (b_sync) b_sync_n++;
        if (b_done) b_done_n++;
        if (b_dval) begin
            if (qb.size() == 0) begin
                check("b_unexpected_dval", 32'(b_dval), 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_data", 32'(b_data), 32'(eb.d));
                check("b_x_cont", 32'(b_x), 32'(eb.x));
                check("b_y_cont", 32'(b_y), 32'(eb.y));
                check("b_addr", 32'(b_addr), eb.addr);
                check("b_bank_sel", 32'(b_sel), 32'd1);
                check("b_bank_addr", 32'(b_baddr), eb.addr);
            end
        end else begin
            check("b_bank_sel_idle", 32'(b_sel), 32'd0);
        end
    end

    // ev_kind: 0 none, 1 release reset, 2 stop pulse + drop start, 3 new iX_POS, 4 raise start
    task automatic send_frame(input int nl, input int lmin, input int lmax, input bit cap,
                              input int ev_line, input int ev_kind, input logic [15:0] ev_val);
        int xp, yp, len;
        @(negedge clk);
        xp   = int'(xpos);
        yp   = int'(ypos);
        fval = 1'b1;
        lval = 1'b0;
        repeat (3) @(negedge clk);
        for (int y = 0; y < nl; y++) begin
            if (y == ev_line) begin
                case (ev_kind)
                    1: rst_n = 1'b1;
                    2: begin stop = 1'b1; start = 1'b0; @(negedge clk); stop = 1'b0; end
                    3: xpos = ev_val;
                    4: start = 1'b1;
                    default: ;
                endcase
            end
            len = int'($urandom_range(lmax, lmin));
            for (int x = 0; x < len; x++) begin
                lval = 1'b1;
                data = 8'($urandom);
                if (cap) model_pixel(x, y, xp, yp, data);
                @(negedge clk);
            end
            lval = 1'b0;
            repeat ($urandom_range(4, 2)) @(negedge clk);
        end
        fval = 1'b0;
        repeat (8) @(negedge clk);
        if (cap) frames_exp++;
        check("a_frame_cont", a_fc, 32'(frames_exp));
        check("b_frame_cont", b_fc, 32'(frames_exp));
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; stop = 1'b0;
        fval = 1'b0; lval = 1'b0; data = 8'd0;
        xpos = 16'd2; ypos = 16'd1;
        repeat (3) @(negedge clk);
        check("rst_a_dval", 32'(a_dval), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        check("rst_a_x", 32'(a_x), 32'd0);
        check("rst_a_frame_cont", a_fc, 32'd0);
        check("rst_a_sync", 32'(a_sync), 32'd0);
        check("rst_b_dval", 32'(b_dval), 32'd0);

        // reset released mid-frame with start held: that partial frame is skipped
        send_frame(6, 12, 12, 1'b0, 2, 1, 16'd0);
        check("no_sync_partial", 32'(a_sync_n), 32'd0);

        // full 12x6 frame, window at (2,1)
        send_frame(6, 12, 12, 1'b1, -1, 0, 16'd0);
        check("a_sync_one", 32'(a_sync_n), 32'd1);
        check("b_sync_one", 32'(b_sync_n), 32'd1);
        check("a_done_one", 32'(a_done_n), 32'd1);

        // window at origin; decimated instance keeps X 0,2,4,6 on Y 0,2
        xpos = 16'd0; ypos = 16'd0;
        send_frame(6, 12, 12, 1'b1, -1, 0, 16'd0);

        // short lines and short frames at random origins
        for (int i = 0; i < 4; i++) begin
            xpos = 16'($urandom_range(3, 0));
            ypos = 16'($urandom_range(2, 0));
            send_frame(int'($urandom_range(7, 2)), 2, 13, 1'b1, -1, 0, 16'd0);
        end

        // origin changed mid-frame applies from the next frame
        xpos = 16'd1; ypos = 16'd0;
        send_frame(6, 12, 12, 1'b1, 2, 3, 16'd4);
        send_frame(6, 12, 12, 1'b1, -1, 0, 16'd0);

        // stop request mid-frame: this frame completes, next one is ignored
        send_frame(6, 12, 12, 1'b1, 2, 2, 16'd0);
        send_frame(6, 12, 12, 1'b0, -1, 0, 16'd0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        send_frame(5, 10, 12, 1'b0, -1, 0, 16'd0);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(5, 4, 12, 1'b1, -1, 0, 16'd0);

        // armed in the middle of a frame: wait for the next frame start
        stop = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        send_frame(6, 12, 12, 1'b0, 2, 4, 16'd0);
        send_frame(6, 12, 12, 1'b1, -1, 0, 16'd0);

        for (int i = 0; i < 4; i++) begin
            xpos = 16'($urandom_range(4, 0));
            ypos = 16'($urandom_range(3, 0));
            send_frame(int'($urandom_range(9, 1)), 1, 14, 1'b1, -1, 0, 16'd0);
        end

        check("a_sync_total", 32'(a_sync_n), 32'(frames_exp));
        check("b_sync_total", 32'(b_sync_n), 32'(frames_exp));
        check("a_done_total", 32'(a_done_n), 32'(frames_exp));
        check("b_done_total", 32'(b_done_n), 32'(frames_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
